// File: rtl/dino_jump_if.sv
// Keypad/divider inputs and sprite outputs shared between the jump controller
// and whatever drives it (scanner/divider side = master, controller = slave).
interface dino_jump_if;
  logic [4:0] key_code;
  logic       key_ready;
  logic       tick;
  logic       freeze;
  logic [8:0] dino_y;
  logic       jumping;
  logic       ducking;
  logic [7:0] jump_count;

  modport master (
    output key_code, key_ready, tick, freeze,
    input  dino_y, jumping, ducking, jump_count
  );

  modport slave (
    input  key_code, key_ready, tick, freeze,
    output dino_y, jumping, ducking, jump_count
  );
endinterface

// File: rtl/dino_jump_ctrl.sv
// Dinosaur vertical motion controller: turns keypad press events and divider
// tick edges into sprite row, pose flags and a saturating jump counter.
module dino_jump_ctrl #(
  parameter int         GROUND_Y   = 240,
  parameter int         JUMP_STEP  = 4,
  parameter int         RISE_STEPS = 32,
  parameter int         DUCK_STEPS = 16,
  parameter logic [4:0] JUMP_KEY   = 5'h10,
  parameter logic [4:0] DUCK_KEY   = 5'h11
) (
  input  logic        clk,
  input  logic        rst,
  dino_jump_if.slave  bus
);

  localparam logic [8:0] GY = 9'(GROUND_Y);
  localparam logic [8:0] JS = 9'(JUMP_STEP);
  localparam logic [8:0] RS = 9'(RISE_STEPS);
  localparam logic [8:0] DS = 9'(DUCK_STEPS);

  typedef enum logic [1:0] {GROUND, RISE, FALL, DUCK} state_t;

  state_t     state, state_n;
  logic [8:0] dino_y, dino_y_n;
  logic [7:0] step_cnt, step_cnt_n;
  logic       fast, fast_n;
  logic [7:0] jump_count, jump_count_n;
  logic       key_ready_d, tick_d;

  logic       press, step, jump_press, duck_press;
  logic [8:0] cnt_inc;
  logic [9:0] fall_size, fall_sum;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign press      = bus.key_ready & ~key_ready_d;
  assign step       = bus.tick & ~tick_d;
  assign jump_press = press && (bus.key_code == JUMP_KEY);
  assign duck_press = press && (bus.key_code == DUCK_KEY);
  assign cnt_inc    = {1'b0, step_cnt} + 9'd1;
  assign fall_size  = fast ? {JS, 1'b0} : {1'b0, JS};
  // 10-bit sum so a fast step near the ground cannot wrap past the clamp
  assign fall_sum   = {1'b0, dino_y} + fall_size;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= GROUND;
      dino_y      <= GY;
      step_cnt    <= 8'd0;
      fast        <= 1'b0;
      jump_count  <= 8'd0;
      key_ready_d <= 1'b0;
      tick_d      <= 1'b0;
    end else begin
      state       <= state_n;
      dino_y      <= dino_y_n;
      step_cnt    <= step_cnt_n;
      fast        <= fast_n;
      jump_count  <= jump_count_n;
      key_ready_d <= bus.key_ready;
      tick_d      <= bus.tick;
    end
  end

  always_comb begin
    state_n      = state;
    dino_y_n     = dino_y;
    step_cnt_n   = step_cnt;
    fast_n       = fast;
    jump_count_n = jump_count;
    // Frozen cycles drop events outright; edge detectors still track inputs
    if (!bus.freeze) begin
      unique case (state)
        GROUND: begin
          dino_y_n = GY;
          if (jump_press) begin
            state_n    = RISE;
            step_cnt_n = 8'd0;
            fast_n     = 1'b0;
          end else if (duck_press) begin
            state_n    = DUCK;
            step_cnt_n = 8'd0;
          end
        end
        RISE: begin
          if (duck_press) fast_n = 1'b1;
          if (step) begin
            dino_y_n = dino_y - JS;
            if (cnt_inc == RS) begin
              state_n    = FALL;
              step_cnt_n = 8'd0;
            end else begin
              step_cnt_n = cnt_inc[7:0];
            end
          end
        end
        FALL: begin
          if (duck_press) fast_n = 1'b1;
          if (step) begin
            if (fall_sum >= {1'b0, GY}) begin
              dino_y_n     = GY;
              state_n      = GROUND;
              fast_n       = 1'b0;
              jump_count_n = sat_inc8(jump_count);
            end else begin
              dino_y_n = fall_sum[8:0];
            end
          end
        end
        DUCK: begin
          dino_y_n = GY;
          if (jump_press) begin
            state_n    = RISE;
            step_cnt_n = 8'd0;
            fast_n     = 1'b0;
          end else if (duck_press) begin
            step_cnt_n = 8'd0;
          end else if (step) begin
            if (cnt_inc == DS) begin
              state_n    = GROUND;
              step_cnt_n = 8'd0;
            end else begin
              step_cnt_n = cnt_inc[7:0];
            end
          end
        end
        default: state_n = GROUND;
      endcase
    end
  end

  assign bus.dino_y     = dino_y;
  assign bus.jumping    = (state == RISE) || (state == FALL);
  assign bus.ducking    = (state == DUCK);
  assign bus.jump_count = jump_count;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Directed bench for dino_jump_ctrl with hand-computed expected rows and flags.
module tb_dino_jump_ctrl;

  localparam logic [4:0] JUMP = 5'h10;
  localparam logic [4:0] DUCK = 5'h11;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  dino_jump_if ifc ();

  dino_jump_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_steps(input int n);
    for (int i = 0; i < n; i++) begin
      ifc.tick = 1'b1;
      cyc();
      ifc.tick = 1'b0;
      cyc();
    end
  endtask

  task automatic press(input logic [4:0] code);
    ifc.key_code  = code;
    ifc.key_ready = 1'b1;
    cyc();
    ifc.key_ready = 1'b0;
    cyc();
  endtask

  initial begin
    rst           = 1'b1;
    ifc.key_code  = 5'h00;
    ifc.key_ready = 1'b0;
    ifc.tick      = 1'b0;
    ifc.freeze    = 1'b0;
    repeat (3) cyc();
    check("rst_y", ifc.dino_y, 240);
    check("rst_jumping", ifc.jumping, 0);
    check("rst_ducking", ifc.ducking, 0);
    check("rst_count", ifc.jump_count, 0);
    rst = 1'b0;
    cyc();

    do_steps(100);
    check("idle_y", ifc.dino_y, 240);
    check("idle_jumping", ifc.jumping, 0);
    check("idle_ducking", ifc.ducking, 0);

    press(5'h03);
    check("badkey_jumping", ifc.jumping, 0);
    check("badkey_ducking", ifc.ducking, 0);

    // Plain jump: apex 240-32*4, then 32 normal fall steps
    press(JUMP);
    check("jump_start", ifc.jumping, 1);
    do_steps(32);
    check("apex_y", ifc.dino_y, 112);
    do_steps(31);
    check("fall31_y", ifc.dino_y, 236);
    check("fall31_jumping", ifc.jumping, 1);
    do_steps(1);
    check("land_y", ifc.dino_y, 240);
    check("land_jumping", ifc.jumping, 0);
    check("land_count", ifc.jump_count, 1);

    // Fast fall from apex with an ignored second jump mid-rise
    press(JUMP);
    do_steps(10);
    press(JUMP);
    do_steps(22);
    check("dbl_apex_y", ifc.dino_y, 112);
    press(DUCK);
    do_steps(15);
    check("fast15_y", ifc.dino_y, 232);
    do_steps(1);
    check("fast_land_y", ifc.dino_y, 240);
    check("fast_land_count", ifc.jump_count, 2);

    // Fast fall whose last step would overshoot: 236+8 clamps to 240
    press(JUMP);
    do_steps(33);
    check("fall1_y", ifc.dino_y, 116);
    press(DUCK);
    do_steps(15);
    check("clamp_pre_y", ifc.dino_y, 236);
    do_steps(1);
    check("clamp_y", ifc.dino_y, 240);
    check("clamp_jumping", ifc.jumping, 0);

    // Duck lasts 16 steps
    press(DUCK);
    check("duck_on", ifc.ducking, 1);
    do_steps(15);
    check("duck15", ifc.ducking, 1);
    check("duck15_y", ifc.dino_y, 240);
    do_steps(1);
    check("duck_off", ifc.ducking, 0);

    // Jump out of a duck at step 5: flags swap one cycle after the press
    press(DUCK);
    do_steps(5);
    check("duck5", ifc.ducking, 1);
    ifc.key_code  = JUMP;
    ifc.key_ready = 1'b1;
    cyc();
    check("duck_jump_ducking", ifc.ducking, 0);
    check("duck_jump_jumping", ifc.jumping, 1);
    ifc.key_ready = 1'b0;
    cyc();
    do_steps(64);
    check("duck_jump_land_y", ifc.dino_y, 240);
    check("duck_jump_count", ifc.jump_count, 4);

    // Freeze at row 200: steps and presses are discarded, not queued
    press(JUMP);
    do_steps(10);
    check("pre_freeze_y", ifc.dino_y, 200);
    ifc.freeze = 1'b1;
    do_steps(50);
    press(JUMP);
    press(DUCK);
    check("frozen_y", ifc.dino_y, 200);
    check("frozen_jumping", ifc.jumping, 1);
    ifc.freeze = 1'b0;
    cyc();
    check("unfreeze_y", ifc.dino_y, 200);
    do_steps(1);
    check("resume_y", ifc.dino_y, 196);
    do_steps(21);
    check("resume_apex_y", ifc.dino_y, 112);
    do_steps(31);
    check("no_fast_y", ifc.dino_y, 236);
    do_steps(1);
    check("freeze_land_count", ifc.jump_count, 5);

    // Held key_ready is one press: repeated duck presses would keep restarting
    ifc.key_code  = DUCK;
    ifc.key_ready = 1'b1;
    cyc();
    check("hold_duck_on", ifc.ducking, 1);
    do_steps(16);
    repeat (1000 - 33) cyc();
    check("hold_duck_off", ifc.ducking, 0);
    ifc.key_ready = 1'b0;
    cyc();

    // Held tick is one step
    press(JUMP);
    ifc.tick = 1'b1;
    repeat (200) cyc();
    ifc.tick = 1'b0;
    cyc();
    check("hold_tick_y", ifc.dino_y, 236);
    do_steps(31 + 32);
    check("hold_tick_land_y", ifc.dino_y, 240);
    check("hold_tick_count", ifc.jump_count, 6);

    // Counter saturation
    for (int j = 0; j < 300; j++) begin
      press(JUMP);
      do_steps(64);
    end
    check("sat_count", ifc.jump_count, 255);
    check("sat_y", ifc.dino_y, 240);

    // Reset mid-jump
    press(JUMP);
    do_steps(5);
    check("mid_y", ifc.dino_y, 220);
    rst = 1'b1;
    cyc();
    check("midrst_y", ifc.dino_y, 240);
    check("midrst_jumping", ifc.jumping, 0);
    check("midrst_count", ifc.jump_count, 0);
    rst = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
